// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word fall-through FIFO buffering ALU results {op, Y}
// for a valid/ready consumer. The ALU cannot be stalled, so refused writes are
// optionally counted.
// Optional feature macro: ALU_FIFO_DROP_CNT_EN enables the saturating drop_cnt
// counter. When the macro is undefined, drop_cnt is tied to zero.
module alu_result_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 3,
  parameter int unsigned AW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OP_W-1:0]   in_op,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [OP_W-1:0]   out_op,
  input  logic              out_ready,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam int unsigned PTR_W   = AW + 1;
  localparam int unsigned ENTRY_W = OP_W + DATA_W;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] head;
  logic               wr_en;
  logic               rd_en;

  // Status flags come from the registered pointers only; the extra MSB tells full from empty
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count     = wr_ptr - rd_ptr;
  assign in_ready  = !full;
  assign out_valid = !empty;

  // A flush suppresses both transfers; a full FIFO refuses writes even alongside a read
  assign wr_en = in_valid && !full && !clr;
  assign rd_en = out_ready && !empty && !clr;

  // Fall-through head, forced to zero while nothing is stored
  assign head     = mem[rd_ptr[AW-1:0]];
  assign out_data = empty ? '0 : head[DATA_W-1:0];
  assign out_op   = empty ? '0 : head[ENTRY_W-1:DATA_W];

  // Pointer update: reset and flush return both pointers to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage array, intentionally without reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {in_op, in_data};
  end

`ifdef ALU_FIFO_DROP_CNT_EN
  logic [7:0] drop_q;

  // Saturating count of writes refused because the FIFO was full; only rst_n clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 8'h00;
    end else if (in_valid && full && !clr && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: randomized and directed checks of alu_result_fifo
// against a queue-based reference model.
module tb_alu_result_fifo;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned AW     = 2;
  localparam int unsigned DEPTH  = 1 << AW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [OP_W-1:0]   in_op;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [OP_W-1:0]   out_op;
  logic              out_ready;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic [7:0]        drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: stored {op,data} entries in order, plus refused-write tally
  logic [OP_W+DATA_W-1:0] mq[$];
  int m_drops = 0;

  alu_result_fifo #(.DATA_W(DATA_W), .OP_W(OP_W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .in_op(in_op), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_op(out_op), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] m_data();
    logic [OP_W+DATA_W-1:0] e;
    if (mq.size() == 0) return '0;
    e = mq[0];
    return e[DATA_W-1:0];
  endfunction

  function automatic logic [OP_W-1:0] m_op();
    logic [OP_W+DATA_W-1:0] e;
    if (mq.size() == 0) return '0;
    e = mq[0];
    return e[OP_W+DATA_W-1:DATA_W];
  endfunction

  function automatic int m_drop_exp();
`ifdef ALU_FIFO_DROP_CNT_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  // One clock: apply current inputs to the model at the edge, then settle
  task automatic step();
    int sz;
    bit wr;
    bit rd;
    sz = mq.size();
    @(posedge clk);
    if (clr) begin
      mq.delete();
    end else begin
      rd = out_ready && (sz > 0);
      wr = in_valid && (sz < DEPTH);
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back({in_op, in_data});
      if (in_valid && (sz == DEPTH) && (m_drops < 255)) m_drops++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_drops = 0;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    n_cmp++; if (out_op !== 3'b000) begin n_err++; $display("FAIL reset_out_op got=%b exp=000", out_op); end
    n_cmp++; if (drop_cnt !== 8'h00) begin n_err++; $display("FAIL reset_drop_cnt got=%h exp=00", drop_cnt); end
  endtask

  task automatic test_single_write();
    idle_inputs();
    in_valid = 1'b1; in_data = 8'h0C; in_op = 3'b000;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_no_bypass got=%b exp=0", out_valid); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_data !== 8'h0C) begin n_err++; $display("FAIL single_out_data got=%h exp=0c", out_data); end
    n_cmp++; if (out_op !== 3'b000) begin n_err++; $display("FAIL single_out_op got=%b exp=000", out_op); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count got=%0d exp=1", count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_drained got=%b exp=1", empty); end
  endtask

  task automatic test_fill_overflow();
    logic [DATA_W-1:0] got[$];
    int guard;
    idle_inputs();
    in_valid = 1'b1; in_op = 3'd2;
    for (int i = 1; i <= 5; i++) begin
      in_data = DATA_W'(i);
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full got=%b exp=1", full); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ovf_in_ready got=%b exp=0", in_ready); end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL ovf_count got=%0d exp=4", count); end
    n_cmp++; if (int'(drop_cnt) !== m_drop_exp()) begin n_err++; $display("FAIL ovf_drop_cnt got=%0d exp=%0d", drop_cnt, m_drop_exp()); end
    out_ready = 1'b1;
    guard = 0;
    while (out_valid && guard < 10) begin
      got.push_back(out_data);
      step();
      guard++;
    end
    out_ready = 1'b0;
    n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL ovf_drain_len got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        n_cmp++;
        if (got[i] !== DATA_W'(i + 1)) begin n_err++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, got[i], i + 1); end
      end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = DATA_W'(8'h10 + i);
      in_op = OP_W'(i);
      if (i > 0) begin
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL b2b_count[%0d] got=%0d exp=1", i, count); end
        n_cmp++; if (out_data !== DATA_W'(8'h10 + i - 1)) begin n_err++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, out_data, 8'h10 + i - 1); end
      end
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 8'h1B) begin n_err++; $display("FAIL b2b_last got=%h exp=1b", out_data); end
    step();
    out_ready = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_clr();
    logic [7:0] drop_before;
    idle_inputs();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = DATA_W'(8'hA0 + i);
      step();
    end
    drop_before = drop_cnt;
    clr = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL clr_empty got=%b exp=1", empty); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL clr_count got=%0d exp=0", count); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL clr_out_data got=%h exp=00", out_data); end
    n_cmp++; if (drop_cnt !== drop_before) begin n_err++; $display("FAIL clr_drop_cnt got=%h exp=%h", drop_cnt, drop_before); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_write_absent got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 45);
      clr       = ($urandom_range(0, 99) < 3);
      in_data   = DATA_W'($urandom);
      in_op     = OP_W'($urandom);
      step();
      n_cmp++;
      if (int'(count) !== mq.size() || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
          in_ready !== (mq.size() != DEPTH) || out_valid !== (mq.size() != 0) ||
          out_data !== m_data() || out_op !== m_op() || int'(drop_cnt) !== m_drop_exp()) begin
        n_err++;
        $display("FAIL rand[%0d] got cnt=%0d e=%b f=%b d=%h op=%0d drop=%0d exp cnt=%0d d=%h op=%0d drop=%0d",
                 i, count, empty, full, out_data, out_op, drop_cnt, mq.size(), m_data(), m_op(), m_drop_exp());
      end
    end
    idle_inputs();
  endtask

  task automatic test_drop_saturate();
    idle_inputs();
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = DATA_W'(i);
      step();
    end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL sat_full got=%b exp=1", full); end
`ifdef ALU_FIFO_DROP_CNT_EN
    n_cmp++; if (drop_cnt !== 8'hFF) begin n_err++; $display("FAIL sat_drop_cnt got=%h exp=ff", drop_cnt); end
`else
    n_cmp++; if (drop_cnt !== 8'h00) begin n_err++; $display("FAIL sat_drop_tied got=%h exp=00", drop_cnt); end
`endif
    // Reset asserted between edges must take effect without a clock
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (drop_cnt !== 8'h00) begin n_err++; $display("FAIL async_drop_cnt got=%h exp=00", drop_cnt); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL async_empty got=%b exp=1", empty); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL async_count got=%0d exp=0", count); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_drops = 0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_overflow();
    test_back_to_back();
    test_clr();
    test_random();
    test_drop_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
